// File: rtl/sdram_cmd_queue_pkg.sv
// Shared types for the SDRAM command queue: queued command record and FSM states.
package sdram_pkg;

    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } q_state_e;

endpackage

// File: rtl/sdram_cmd_queue_if.sv
// Client-side request/response bundle of the SDRAM command queue.
interface sdram_cmd_queue_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head entry is read combinationally.
module sdram_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Client front end for one SDRAM arbiter port: queues requests, issues them one
// at a time, returns in-order completion pulses and flags stalled completions.
module sdram_cmd_queue
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = CMD_ADDR_W,
    parameter int unsigned DATA_WIDTH     = CMD_DATA_W,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sdram_cmd_queue_if.slave        client,
    output logic [$clog2(DEPTH):0]  level,
    output logic [ADDR_WIDTH-1:0]   sd_addr,
    output logic [DATA_WIDTH-1:0]   sd_write_data,
    output logic                    sd_wr,
    output logic                    sd_rd,
    input  logic                    sd_rdy,
    input  logic                    sd_wvalid,
    input  logic                    sd_rvalid,
    input  logic [DATA_WIDTH-1:0]   sd_read_data
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    q_state_e             state;
    q_state_e             state_d;
    cmd_t                 fifo_din;
    cmd_t                 fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic                 finish;
    logic                 expire;
    logic                 cmd_we;
    logic [TMR_W-1:0]     timer;
    logic                 rsp_valid_q;
    logic                 rsp_we_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                 rsp_err_q;

    // Ready is based on the registered level so a same-cycle pop never lets a push into a full FIFO.
    assign client.req_ready = rst_n & ~fifo_full;
    assign push             = client.req_valid & client.req_ready;
    assign fifo_din         = cmd_t'{we: client.req_we, addr: client.req_addr, wdata: client.req_wdata};

    assign client.rsp_valid = rsp_valid_q;
    assign client.rsp_we    = rsp_we_q;
    assign client.rsp_rdata = rsp_rdata_q;
    assign client.rsp_err   = rsp_err_q;

    sdram_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_rdy) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Only the valid matching the command type completes it.
                if (cmd_we ? sd_wvalid : sd_rvalid) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end else if (timer == TMR_LAST) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we        <= 1'b0;
            sd_addr       <= '0;
            sd_write_data <= '0;
            sd_wr         <= 1'b0;
            sd_rd         <= 1'b0;
            timer         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_we_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (pop) begin
                cmd_we        <= fifo_dout.we;
                sd_addr       <= fifo_dout.addr;
                sd_write_data <= fifo_dout.wdata;
                sd_wr         <= fifo_dout.we;
                sd_rd         <= ~fifo_dout.we;
            end
            if (accept) begin
                sd_wr         <= 1'b0;
                sd_rd         <= 1'b0;
                sd_write_data <= '0;
                timer         <= '0;
            end
            if (state == WAIT && !finish && !expire) begin
                timer <= timer + 1'b1;
            end
            if (finish || expire) begin
                rsp_valid_q <= 1'b1;
                rsp_we_q    <= cmd_we;
                rsp_err_q   <= expire;
                rsp_rdata_q <= (finish && !cmd_we) ? sd_read_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Self-checking bench for sdram_cmd_queue with a behavioural SDRAM port responder.
module tb_sdram_cmd_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  level;
    logic [31:0] sd_addr;
    logic [31:0] sd_write_data;
    logic [31:0] sd_read_data;
    logic        sd_wr, sd_rd, sd_rdy, sd_wvalid, sd_rvalid;

    always #5 clk = ~clk;

    sdram_cmd_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cif ();

    sdram_cmd_queue #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .client        (cif),
        .level         (level),
        .sd_addr       (sd_addr),
        .sd_write_data (sd_write_data),
        .sd_wr         (sd_wr),
        .sd_rd         (sd_rd),
        .sd_rdy        (sd_rdy),
        .sd_wvalid     (sd_wvalid),
        .sd_rvalid     (sd_rvalid),
        .sd_read_data  (sd_read_data)
    );

    typedef struct { logic we; logic [31:0] rdata; logic err; } exp_t;
    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata;
        int rdy_delay; int rsp_delay; bit wrong_first;
    } cfg_t;
    typedef struct { cfg_t c; exp_t e; } vec_t;

    exp_t        exp_q[$];
    cfg_t        cfg_q[$];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    int          checks = 0;
    int          fails = 0;
    bit          busy = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(string name, string why);
        checks++;
        fails++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    function automatic cfg_t mk_cfg(logic we, logic [31:0] addr, logic [31:0] wdata,
                                    int rdy_delay, int rsp_delay, bit wrong_first);
        cfg_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        c.rdy_delay = rdy_delay; c.rsp_delay = rsp_delay; c.wrong_first = wrong_first;
        return c;
    endfunction

    function automatic exp_t mk_exp(logic we, logic [31:0] rdata, logic err);
        exp_t e;
        e.we = we; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    task automatic push_req(cfg_t c, exp_t e);
        int n = 0;
        @(negedge clk);
        cif.req_valid = 1'b1;
        cif.req_we    = c.we;
        cif.req_addr  = c.addr;
        cif.req_wdata = c.wdata;
        while (!cif.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cif.req_ready) begin
            fail("push_timeout", "req_ready never rose");
            cif.req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        cfg_q.push_back(c);
        @(posedge clk);
        #1 cif.req_valid = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || level != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) fail("drain_timeout", "responses outstanding after budget");
        check("drain_level", 32'(level), 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_sd_wr"}, 32'(sd_wr), 0);
        check({tag, "_sd_rd"}, 32'(sd_rd), 0);
        check({tag, "_sd_addr"}, sd_addr, 0);
        check({tag, "_sd_wdata"}, sd_write_data, 0);
        check({tag, "_rsp_valid"}, 32'(cif.rsp_valid), 0);
        check({tag, "_rsp_we"}, 32'(cif.rsp_we), 0);
        check({tag, "_rsp_rdata"}, cif.rsp_rdata, 0);
        check({tag, "_rsp_err"}, 32'(cif.rsp_err), 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_req_ready"}, 32'(cif.req_ready), 0);
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cif.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_rsp", $sformatf("rsp_we=%0d rdata=%h err=%0d",
                         cif.rsp_we, cif.rsp_rdata, cif.rsp_err));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_we", 32'(cif.rsp_we), 32'(e.we));
                    check("rsp_rdata", cif.rsp_rdata, e.rdata);
                    check("rsp_err", 32'(cif.rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Behavioural port: accepts each strobe after rdy_delay, then completes after rsp_delay (<0 never).
    initial begin
        cfg_t c;
        int   n;
        sd_rdy = 1'b0; sd_wvalid = 1'b0; sd_rvalid = 1'b0; sd_read_data = '1;
        forever begin
            @(negedge clk);
            if (rst_n && (sd_wr || sd_rd)) begin
                busy = 1'b1;
                if (cfg_q.size() == 0) begin
                    fail("unexpected_strobe", "strobe with no queued request");
                    c = mk_cfg(sd_wr, sd_addr, sd_write_data, 0, 0, 1'b0);
                end else begin
                    c = cfg_q.pop_front();
                end
                check("strobe_onehot", 32'(sd_wr ^ sd_rd), 1);
                check("strobe_type", 32'(sd_wr), 32'(c.we));
                check("sd_addr", sd_addr, c.addr);
                if (c.we) check("sd_write_data", sd_write_data, c.wdata);
                for (int i = 0; i < c.rdy_delay; i++) begin
                    @(negedge clk);
                    check("hold_strobe", 32'({sd_wr, sd_rd}), 32'({c.we, ~c.we}));
                    check("hold_addr", sd_addr, c.addr);
                end
                sd_rdy = 1'b1;
                @(negedge clk);
                sd_rdy = 1'b0;
                check("strobe_drop", 32'({sd_wr, sd_rd}), 0);
                check("wdata_clear", sd_write_data, 0);
                if (c.we) slave_mem[c.addr] = c.wdata;
                if (c.wrong_first) begin
                    if (c.we) sd_rvalid = 1'b1;
                    else      sd_wvalid = 1'b1;
                    @(negedge clk);
                    sd_rvalid = 1'b0;
                    sd_wvalid = 1'b0;
                end
                if (c.rsp_delay < 0) begin
                    n = 0;
                    while (!cif.rsp_valid && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    check("timeout_latency", 32'(n), TIMEOUT);
                end else begin
                    repeat (c.rsp_delay) @(negedge clk);
                    if (c.we) begin
                        sd_wvalid = 1'b1;
                    end else begin
                        sd_rvalid    = 1'b1;
                        sd_read_data = slave_mem.exists(c.addr) ? slave_mem[c.addr] : 32'h0BAD_F00D;
                    end
                    @(negedge clk);
                    sd_wvalid = 1'b0; sd_rvalid = 1'b0; sd_read_data = '1;
                end
                busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[9];
        logic [31:0] a, d;
        int          strobes;

        tbl[0] = '{mk_cfg(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 0, 0, 1'b0),  mk_exp(1'b1, 32'h0, 1'b0)};
        tbl[1] = '{mk_cfg(1'b0, 32'h0000_1234, 32'h0,         0, 0, 1'b0),  mk_exp(1'b0, 32'hDEAD_BEEF, 1'b0)};
        tbl[2] = '{mk_cfg(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 3, 5, 1'b0),  mk_exp(1'b1, 32'h0, 1'b0)};
        tbl[3] = '{mk_cfg(1'b0, 32'h0000_0040, 32'h0,         1, 2, 1'b1),  mk_exp(1'b0, 32'hA5A5_5A5A, 1'b0)};
        tbl[4] = '{mk_cfg(1'b1, 32'h0000_0080, 32'h1234_5678, 0, 1, 1'b1),  mk_exp(1'b1, 32'h0, 1'b0)};
        tbl[5] = '{mk_cfg(1'b0, 32'h0000_0080, 32'h0,         2, -1, 1'b0), mk_exp(1'b0, 32'h0, 1'b1)};
        tbl[6] = '{mk_cfg(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0, -1, 1'b0), mk_exp(1'b1, 32'h0, 1'b1)};
        tbl[7] = '{mk_cfg(1'b0, 32'h0000_0040, 32'h0,         0, 15, 1'b0), mk_exp(1'b0, 32'hA5A5_5A5A, 1'b0)};
        tbl[8] = '{mk_cfg(1'b0, 32'h0000_1234, 32'h0,         0, 16, 1'b0), mk_exp(1'b0, 32'h0, 1'b1)};

        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(cif.req_ready), 1);
        check("post_reset_level", 32'(level), 0);

        foreach (tbl[i]) begin
            push_req(tbl[i].c, tbl[i].e);
            wait_drain(100);
        end

        // Fill: first command stalls in ISSUE while the FIFO fills behind it.
        push_req(mk_cfg(1'b1, 32'h300, 32'h1111_1111, 20, 1, 1'b0), mk_exp(1'b1, 32'h0, 1'b0));
        push_req(mk_cfg(1'b0, 32'h300, 32'h0,         0, 2, 1'b0), mk_exp(1'b0, 32'h1111_1111, 1'b0));
        push_req(mk_cfg(1'b1, 32'h304, 32'h2222_2222, 1, 0, 1'b0), mk_exp(1'b1, 32'h0, 1'b0));
        push_req(mk_cfg(1'b0, 32'h304, 32'h0,         0, 3, 1'b0), mk_exp(1'b0, 32'h2222_2222, 1'b0));
        push_req(mk_cfg(1'b0, 32'h300, 32'h0,         2, 0, 1'b0), mk_exp(1'b0, 32'h1111_1111, 1'b0));
        @(negedge clk);
        check("fill_level", 32'(level), DEPTH);
        cif.req_valid = 1'b1; cif.req_we = 1'b1; cif.req_addr = 32'h308; cif.req_wdata = 32'h3333_3333;
        repeat (3) begin
            check("fill_ready", 32'(cif.req_ready), 0);
            @(negedge clk);
            check("fill_level_hold", 32'(level), DEPTH);
        end
        cif.req_valid = 1'b0;
        wait_drain(300);

        // Long ISSUE stall must not trip the watchdog.
        push_req(mk_cfg(1'b1, 32'h400, 32'h7777_7777, 50, 2, 1'b0), mk_exp(1'b1, 32'h0, 1'b0));
        wait_drain(200);

        // Timed-out read followed by a queued read that must still complete.
        push_req(mk_cfg(1'b0, 32'h400, 32'h0, 0, -1, 1'b0), mk_exp(1'b0, 32'h0, 1'b1));
        push_req(mk_cfg(1'b0, 32'h400, 32'h0, 0, 3, 1'b0),  mk_exp(1'b0, 32'h7777_7777, 1'b0));
        wait_drain(200);

        // Asynchronous reset while one command waits and two are queued.
        push_req(mk_cfg(1'b1, 32'h500, 32'h5555_0000, 0, 12, 1'b0), mk_exp(1'b1, 32'h0, 1'b0));
        push_req(mk_cfg(1'b1, 32'h504, 32'h5555_0004, 0, 0, 1'b0),  mk_exp(1'b1, 32'h0, 1'b0));
        push_req(mk_cfg(1'b1, 32'h508, 32'h5555_0008, 0, 0, 1'b0),  mk_exp(1'b1, 32'h0, 1'b0));
        repeat (2) @(negedge clk);
        check("pre_reset_level", 32'(level), 2);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        cfg_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease_ready", 32'(cif.req_ready), 1);
        strobes = 0;
        repeat (30) begin
            @(negedge clk);
            if (sd_wr || sd_rd) strobes++;
        end
        check("after_reset_strobes", 32'(strobes), 0);
        check("after_reset_level", 32'(level), 0);
        wait_drain(100);

        // Random write/read pairs, pushed back to back.
        for (int i = 0; i < 10; i++) begin
            a = 32'h1000 + 32'(i) * 8;
            d = $urandom;
            ref_mem[a] = d;
            push_req(mk_cfg(1'b1, a, d, $urandom_range(0, 3), $urandom_range(0, 10), 1'b0),
                     mk_exp(1'b1, 32'h0, 1'b0));
            push_req(mk_cfg(1'b0, a, 32'h0, $urandom_range(0, 3), $urandom_range(0, 10), 1'b0),
                     mk_exp(1'b0, ref_mem[a], 1'b0));
        end
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
